crc5_nibble_checker: RTL and testbench
======================================

Name: crc5_nibble_checker

Overview:
Receive-side counterpart to the team's parallel x^5+x^2+1 nibble CRC generator. Accepts a framed stream of 4-bit nibbles: payload nibbles followed by two CRC nibbles. Recomputes CRC-5 over the payload, compares it against the received CRC, and reports a per-frame result. Also keeps saturating good/bad frame counters. Sits on the link receive path, after the deserializer and before the frame consumer.

Parameters:
LEN_W, 8, width of the payload nibble counter and of res_len
MAX_NIBBLES, 255, maximum legal payload length in nibbles; must be <= 2^LEN_W - 1
CNT_W, 16, width of the good/bad frame counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
in_valid  in  1  nibble present on in_data this cycle
in_data  in  4  received nibble
in_sop  in  1  qualifies the first payload nibble of a frame
in_last  in  1  qualifies the last payload nibble of a frame (may coincide with in_sop)
res_valid  out  1  one-cycle pulse: frame result valid
res_ok  out  1  CRC matched, no length error, no abort
res_abort  out  1  frame ended by a new in_sop before completion
res_len_err  out  1  payload exceeded MAX_NIBBLES
res_crc  out  5  CRC computed over the payload
res_len  out  LEN_W  payload nibbles accepted (saturates at MAX_NIBBLES+1)
cnt_ok  out  CNT_W  frames with res_ok=1, saturating
cnt_bad  out  CNT_W  frames with res_ok=0 (including aborts), saturating

Behaviour:
- CRC algorithm:
  - poly 5'b00101 (x^5+x^2+1); init 5'h00; no reflection; no final XOR.
  - Each nibble is processed MSB first (in_data[3] first). Per bit: fb=c[4]^d; c={c[3:0],1'b0}; if fb, c^=5'b00101.
  - Four bit-steps are unrolled combinationally, so one nibble is absorbed per cycle.
- Received CRC encoding: nibble CRC_LO = crc[3:0]; next nibble CRC_HI = {3'b000, crc[4]}. Nonzero CRC_HI[3:1] counts as a mismatch.
- FSM states: IDLE, PAYLOAD, CRC_LO, CRC_HI. A nibble is consumed only when in_valid=1; there is no backpressure.
  - IDLE: in_valid and in_sop: crc=step(0,in_data), len=1. Go to CRC_LO if in_last, else PAYLOAD. in_valid without in_sop is ignored and the state is unchanged.
  - PAYLOAD: in_valid: crc=step(crc,in_data), len+1 (saturating). Go to CRC_LO if in_last.
  - CRC_LO: in_valid: capture rx_lo. Go to CRC_HI.
  - CRC_HI: in_valid: compare {in_data[0],rx_lo} with crc and in_data[3:1]==0. Go to IDLE.
- In PAYLOAD, CRC_LO or CRC_HI, in_valid with in_sop aborts the current frame:
  - Emit a result with res_abort=1 and res_ok=0.
  - That same nibble starts a new frame exactly as in IDLE.
  - in_sop/in_last are don't-care on CRC nibbles unless in_sop=1 (abort).
- Length error: once len exceeds MAX_NIBBLES, len_err is set and len holds at MAX_NIBBLES+1. The frame continues to completion with res_ok=0.
- Result timing:
  - res_* outputs are registered and valid in the cycle after the completing/aborting nibble; res_valid is high for exactly one cycle.
  - Result fields hold their values until the next result.
  - A new frame may start in the same cycle res_valid is high.
- Counters: on each res_valid, cnt_ok or cnt_bad increments by 1. Neither wraps; each holds at 2^CNT_W-1.
- Reset (rst=0 at a clock edge): state=IDLE, crc=0, len=0, and all outputs 0 including the counters. A frame in flight is discarded with no result. rst has priority over all inputs.

Test Plan:
- Payload {1}, CRC nibbles {5,0} -> res_valid 1 cycle after the 3rd nibble; res_ok=1, res_crc=5'h05, res_len=1, cnt_ok=1.
- Payload {1,0} with in_last on the 2nd nibble, CRC {A,1} -> res_ok=1, res_crc=5'h1A, res_len=2. Repeating with CRC {A,0} gives res_ok=0 and cnt_bad=1.
- Payload {1}, CRC {5,2} (CRC_HI[3:1] nonzero) -> res_ok=0, res_crc=5'h05.
- Payload {1,0,...} with in_sop on the 3rd nibble -> res_valid with res_abort=1 and cnt_bad+1. The new frame {1},{5,0} then passes with res_ok=1. Idle gaps (in_valid=0) inside a frame change nothing.
- MAX_NIBBLES=3: 4-nibble payload -> res_len_err=1, res_len=4, res_ok=0. Separately, CNT_W=2 with 5 good frames -> cnt_ok holds at 3.
- Assert rst=0 while in CRC_LO -> no res_valid, counters=0. Afterwards {1},{5,0} -> res_ok=1.

Source files
------------

// File: rtl/crc5_nibble_checker.sv
// crc5_nibble_checker
// Receive-side CRC-5 (x^5+x^2+1) checker for a framed 4-bit nibble stream.
// Each frame carries payload nibbles followed by CRC_LO = crc[3:0] and
// CRC_HI = {3'b000, crc[4]}. One nibble is absorbed per cycle. A registered
// one-cycle result is produced per frame, and saturating good/bad frame
// counters are maintained.
module crc5_nibble_checker #(
    parameter int LEN_W       = 8,
    parameter int MAX_NIBBLES = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             in_sop,
    input  logic             in_last,
    output logic             res_valid,
    output logic             res_ok,
    output logic             res_abort,
    output logic             res_len_err,
    output logic [4:0]       res_crc,
    output logic [LEN_W-1:0] res_len,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_bad
);

    // Frame-tracking states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CRC_LO  = 2'd2;
    localparam logic [1:0] ST_CRC_HI  = 2'd3;

    localparam logic [4:0] POLY = 5'b00101;

    // Length saturation point: MAX_NIBBLES+1, clipped to what LEN_W can hold
    // so that a full-range MAX_NIBBLES does not wrap the counter.
    localparam int LEN_ALL_ONES = (1 << LEN_W) - 1;
    localparam int LEN_LIM_I    = (MAX_NIBBLES + 1 > LEN_ALL_ONES) ? LEN_ALL_ONES
                                                                   : MAX_NIBBLES + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_NIBBLES);
    localparam logic [LEN_W-1:0] LEN_LIM = LEN_W'(LEN_LIM_I);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Four unrolled MSB-first bit steps of the serial CRC-5 LFSR.
    function automatic logic [4:0] crc_step(input logic [4:0] c_in, input logic [3:0] d);
        logic [4:0] c;
        logic       fb;
        c = c_in;
        for (int i = 3; i >= 0; i--) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Saturating length increment; reports whether the new length is illegal.
    function automatic logic [LEN_W:0] len_inc(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] n;
        logic             err;
        if (len >= LEN_MAX) begin
            n   = LEN_LIM;
            err = 1'b1;
        end else begin
            n   = len + LEN_ONE;
            err = 1'b0;
        end
        return {err, n};
    endfunction

    // Frame state
    logic [1:0]       state_q, state_d;
    logic [4:0]       crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             len_err_q, len_err_d;
    logic [3:0]       rx_lo_q, rx_lo_d;

    // Result being produced this cycle (registered into res_* below)
    logic             fire_d;
    logic             ok_d;
    logic             abort_d;
    logic             res_len_err_d;
    logic [4:0]       res_crc_d;
    logic [LEN_W-1:0] res_len_d;

    logic [4:0]       crc_cont;
    logic [4:0]       crc_start;
    logic [LEN_W:0]   len_next;
    logic             crc_match;

    assign crc_cont  = crc_step(crc_q, in_data);
    assign crc_start = crc_step(5'h00, in_data);
    assign len_next  = len_inc(len_q);
    assign crc_match = ({in_data[0], rx_lo_q} == crc_q) && (in_data[3:1] == 3'b000);

    // Next-state and result decode for one nibble per cycle
    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        len_err_d     = len_err_q;
        rx_lo_d       = rx_lo_q;
        fire_d        = 1'b0;
        ok_d          = 1'b0;
        abort_d       = 1'b0;
        res_len_err_d = len_err_q;
        res_crc_d     = crc_q;
        res_len_d     = len_q;

        if (in_valid) begin
            if (in_sop) begin
                // A start-of-frame mid-frame closes the old frame as aborted;
                // the same nibble always opens a fresh frame.
                if (state_q != ST_IDLE) begin
                    fire_d  = 1'b1;
                    abort_d = 1'b1;
                end
                crc_d     = crc_start;
                len_d     = LEN_ONE;
                len_err_d = (MAX_NIBBLES < 1);
                state_d   = in_last ? ST_CRC_LO : ST_PAYLOAD;
            end else begin
                case (state_q)
                    ST_PAYLOAD: begin
                        crc_d     = crc_cont;
                        len_d     = len_next[LEN_W-1:0];
                        len_err_d = len_err_q | len_next[LEN_W];
                        if (in_last) begin
                            state_d = ST_CRC_LO;
                        end
                    end
                    ST_CRC_LO: begin
                        rx_lo_d = in_data;
                        state_d = ST_CRC_HI;
                    end
                    ST_CRC_HI: begin
                        fire_d  = 1'b1;
                        ok_d    = crc_match && !len_err_q;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        // IDLE: nibbles outside a frame are dropped
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= 5'h00;
            len_q     <= '0;
            len_err_q <= 1'b0;
            rx_lo_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            rx_lo_q   <= rx_lo_d;
        end
    end

    // Result registers: pulse valid, hold fields until the next result
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_valid   <= 1'b0;
            res_ok      <= 1'b0;
            res_abort   <= 1'b0;
            res_len_err <= 1'b0;
            res_crc     <= 5'h00;
            res_len     <= '0;
        end else begin
            res_valid <= fire_d;
            if (fire_d) begin
                res_ok      <= ok_d;
                res_abort   <= abort_d;
                res_len_err <= res_len_err_d;
                res_crc     <= res_crc_d;
                res_len     <= res_len_d;
            end
        end
    end

    // Saturating good/bad frame counters, updated alongside the result
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_ok  <= '0;
            cnt_bad <= '0;
        end else if (fire_d) begin
            if (ok_d) begin
                if (cnt_ok != CNT_TOP) begin
                    cnt_ok <= cnt_ok + CNT_ONE;
                end
            end else begin
                if (cnt_bad != CNT_TOP) begin
                    cnt_bad <= cnt_bad + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc5_nibble_checker.sv
// Directed testbench for crc5_nibble_checker. Two instances share stimulus:
// a default-parameter one and a small one (MAX_NIBBLES=3, CNT_W=2) used for
// the length-error and counter-saturation cases.
module tb_crc5_nibble_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_sop;
    logic       in_last;

    logic        a_valid, a_ok, a_abort, a_lerr;
    logic [4:0]  a_crc;
    logic [7:0]  a_len;
    logic [15:0] a_cok, a_cbad;

    logic        b_valid, b_ok, b_abort, b_lerr;
    logic [4:0]  b_crc;
    logic [7:0]  b_len;
    logic [1:0]  b_cok, b_cbad;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    crc5_nibble_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_last(in_last),
        .res_valid(a_valid), .res_ok(a_ok), .res_abort(a_abort),
        .res_len_err(a_lerr), .res_crc(a_crc), .res_len(a_len),
        .cnt_ok(a_cok), .cnt_bad(a_cbad)
    );

    crc5_nibble_checker #(.LEN_W(8), .MAX_NIBBLES(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_last(in_last),
        .res_valid(b_valid), .res_ok(b_ok), .res_abort(b_abort),
        .res_len_err(b_lerr), .res_crc(b_crc), .res_len(b_len),
        .cnt_ok(b_cok), .cnt_bad(b_cbad)
    );

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic drive(input logic v, input logic [3:0] d, input logic s, input logic l);
        @(negedge clk);
        in_valid = v; in_data = d; in_sop = s; in_last = l;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        idle();
        idle();
        nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", a_valid); end
        nvec++; if (a_ok !== 1'b0 || a_abort !== 1'b0 || a_lerr !== 1'b0) begin nerr++; $display("FAIL reset_flags got %b%b%b want 000", a_ok, a_abort, a_lerr); end
        nvec++; if (a_crc !== 5'h00 || a_len !== 8'h00) begin nerr++; $display("FAIL reset_fields crc %h len %0d want 0 0", a_crc, a_len); end
        nvec++; if (a_cok !== 16'd0 || a_cbad !== 16'd0) begin nerr++; $display("FAIL reset_cnt ok %0d bad %0d want 0 0", a_cok, a_cbad); end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_single();
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1) begin nerr++; $display("FAIL single_ok valid %b ok %b want 1 1", a_valid, a_ok); end
        nvec++; if (a_crc !== 5'h05 || a_len !== 8'd1) begin nerr++; $display("FAIL single_fields crc %h len %0d want 05 1", a_crc, a_len); end
        nvec++; if (a_abort !== 1'b0 || a_lerr !== 1'b0) begin nerr++; $display("FAIL single_flags abort %b lerr %b want 0 0", a_abort, a_lerr); end
        idle();
        nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL single_pulse valid %b want 0", a_valid); end
        nvec++; if (a_cok !== 16'd1 || a_cbad !== 16'd0) begin nerr++; $display("FAIL single_cnt ok %0d bad %0d want 1 0", a_cok, a_cbad); end
        nvec++; if (a_ok !== 1'b1 || a_crc !== 5'h05) begin nerr++; $display("FAIL single_hold ok %b crc %h want 1 05", a_ok, a_crc); end
    endtask

    task automatic test_two_nibble();
        drive(1'b1, 4'h1, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1) begin nerr++; $display("FAIL two_ok valid %b ok %b want 1 1", a_valid, a_ok); end
        nvec++; if (a_crc !== 5'h1A || a_len !== 8'd2) begin nerr++; $display("FAIL two_fields crc %h len %0d want 1a 2", a_crc, a_len); end
        drive(1'b1, 4'h1, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b0) begin nerr++; $display("FAIL two_bad valid %b ok %b want 1 0", a_valid, a_ok); end
        nvec++; if (a_crc !== 5'h1A) begin nerr++; $display("FAIL two_bad_crc got %h want 1a", a_crc); end
        idle();
        nvec++; if (a_cok !== 16'd2 || a_cbad !== 16'd1) begin nerr++; $display("FAIL two_cnt ok %0d bad %0d want 2 1", a_cok, a_cbad); end
    endtask

    task automatic test_hi_nonzero();
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b0) begin nerr++; $display("FAIL hi_nz valid %b ok %b want 1 0", a_valid, a_ok); end
        nvec++; if (a_crc !== 5'h05) begin nerr++; $display("FAIL hi_nz_crc got %h want 05", a_crc); end
        idle();
        nvec++; if (a_cbad !== 16'd2) begin nerr++; $display("FAIL hi_nz_cnt bad %0d want 2", a_cbad); end
    endtask

    task automatic test_abort_gaps();
        drive(1'b1, 4'h1, 1'b1, 1'b0);
        idle();
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL gap_novalid got %b want 0", a_valid); end
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_abort !== 1'b1 || a_ok !== 1'b0) begin nerr++; $display("FAIL abort_res valid %b abort %b ok %b want 1 1 0", a_valid, a_abort, a_ok); end
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL abort_pulse got %b want 0", a_valid); end
        idle();
        idle();
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1 || a_abort !== 1'b0) begin nerr++; $display("FAIL after_abort valid %b ok %b abort %b want 1 1 0", a_valid, a_ok, a_abort); end
        nvec++; if (a_crc !== 5'h05 || a_len !== 8'd1) begin nerr++; $display("FAIL after_abort_fields crc %h len %0d want 05 1", a_crc, a_len); end
        idle();
        nvec++; if (a_cok !== 16'd3 || a_cbad !== 16'd3) begin nerr++; $display("FAIL abort_cnt ok %0d bad %0d want 3 3", a_cok, a_cbad); end
    endtask

    task automatic test_len_err();
        // Payload {1,0,0,0} has CRC 5'h13 -> CRC nibbles {3,1}
        drive(1'b1, 4'h1, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 4'h3, 1'b0, 1'b0);
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        idle();
        nvec++; if (b_valid !== 1'b1 || b_lerr !== 1'b1 || b_ok !== 1'b0) begin nerr++; $display("FAIL lenerr_small valid %b lerr %b ok %b want 1 1 0", b_valid, b_lerr, b_ok); end
        nvec++; if (b_len !== 8'd4 || b_crc !== 5'h13) begin nerr++; $display("FAIL lenerr_small_fields len %0d crc %h want 4 13", b_len, b_crc); end
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1 || a_lerr !== 1'b0) begin nerr++; $display("FAIL len4_dflt valid %b ok %b lerr %b want 1 1 0", a_valid, a_ok, a_lerr); end
        nvec++; if (a_len !== 8'd4 || a_crc !== 5'h13) begin nerr++; $display("FAIL len4_dflt_fields len %0d crc %h want 4 13", a_len, a_crc); end
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        nvec++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got %b %b want 0 0", a_valid, b_valid); end
        nvec++; if (a_cok !== 16'd0 || a_cbad !== 16'd0 || b_cok !== 2'd0 || b_cbad !== 2'd0) begin nerr++; $display("FAIL rstmid_cnt %0d %0d %0d %0d want 0 0 0 0", a_cok, a_cbad, b_cok, b_cbad); end
        idle();
        nvec++; if (a_valid !== 1'b0 || a_ok !== 1'b0 || a_crc !== 5'h00) begin nerr++; $display("FAIL rstmid_after valid %b ok %b crc %h want 0 0 00", a_valid, a_ok, a_crc); end
        drive(1'b1, 4'h1, 1'b1, 1'b1);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1) begin nerr++; $display("FAIL rstmid_frame valid %b ok %b want 1 1", a_valid, a_ok); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h1, 1'b1, 1'b1);
            if (i > 0) begin
                nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1) begin nerr++; $display("FAIL b2b_%0d valid %b ok %b want 1 1", i, a_valid, a_ok); end
            end
            drive(1'b1, 4'h5, 1'b0, 1'b0);
            drive(1'b1, 4'h0, 1'b0, 1'b0);
        end
        idle();
        nvec++; if (a_valid !== 1'b1 || a_ok !== 1'b1) begin nerr++; $display("FAIL b2b_last valid %b ok %b want 1 1", a_valid, a_ok); end
        idle();
        nvec++; if (a_cok !== 16'd5 || a_cbad !== 16'd0) begin nerr++; $display("FAIL cnt_dflt ok %0d bad %0d want 5 0", a_cok, a_cbad); end
        nvec++; if (b_cok !== 2'd3 || b_cbad !== 2'd0) begin nerr++; $display("FAIL cnt_sat ok %0d bad %0d want 3 0", b_cok, b_cbad); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_data = 4'h0; in_sop = 1'b0; in_last = 1'b0;
        test_reset();
        test_single();
        test_two_nibble();
        test_hi_nonzero();
        test_abort_gaps();
        test_len_err();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
